// File: rtl/muldiv_unit.sv
// Iterative MIPS multiply/divide unit holding the architectural HI/LO registers.
// Runs MULT/MULTU (shift-add) and DIV/DIVU (restoring) in WIDTH+1 cycles; also services MTHI/MTLO.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN
    } state_t;

    state_t state, state_next;

    logic [CW-1:0]    count;
    logic             is_div;
    logic             dz;
    logic             neg_main;
    logic             neg_rem;
    logic [WIDTH-1:0] raw_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH+1:0] div_diff;
    logic             div_fits;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] product_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (start) state_next = CALC;
            CALC: if (count == LAST) state_next = SIGN;
            SIGN: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Both algorithms run on magnitudes; signs are restored in SIGN.
    always_comb begin
        a_neg       = op[0] & opA[WIDTH-1];
        b_neg       = op[0] & opB[WIDTH-1];
        a_mag       = a_neg ? -opA : opA;
        b_mag       = b_neg ? -opB : opB;
        mul_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, op_b} : {(WIDTH+1){1'b0}});
        div_shift   = {acc_hi, acc_lo[WIDTH-1]};
        div_diff    = {1'b0, div_shift} - {2'b00, op_b};
        // No borrow leaves the difference below the divisor, so its top two bits are zero.
        div_fits    = (div_diff[WIDTH+1:WIDTH] == 2'b00);
        product     = {acc_hi, acc_lo};
        product_fix = neg_main ? -product : product;
        quot_fix    = neg_main ? -acc_lo : acc_lo;
        rem_fix     = neg_rem ? -acc_hi : acc_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count       <= '0;
            is_div      <= 1'b0;
            dz          <= 1'b0;
            neg_main    <= 1'b0;
            neg_rem     <= 1'b0;
            raw_a       <= '0;
            op_b        <= '0;
            acc_hi      <= '0;
            acc_lo      <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        count    <= '0;
                        is_div   <= op[1];
                        dz       <= op[1] & (opB == '0);
                        neg_main <= a_neg ^ b_neg;
                        neg_rem  <= a_neg;
                        raw_a    <= opA;
                        op_b     <= b_mag;
                        acc_hi   <= '0;
                        acc_lo   <= a_mag;
                    end else begin
                        if (hi_we) hi <= wdata;
                        if (lo_we) lo <= wdata;
                    end
                end
                CALC: begin
                    count <= count + CW'(1);
                    if (is_div) begin
                        if (div_fits) begin
                            {acc_hi, acc_lo} <= {div_diff[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            {acc_hi, acc_lo} <= {div_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        {acc_hi, acc_lo} <= {mul_sum, acc_lo[WIDTH-1:1]};
                    end
                end
                SIGN: begin
                    done        <= 1'b1;
                    div_by_zero <= dz;
                    if (is_div) begin
                        if (dz) begin
                            lo <= '1;
                            hi <= raw_a;
                        end else begin
                            lo <= quot_fix;
                            hi <= rem_fix;
                        end
                    end else begin
                        {hi, lo} <= product_fix;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed operations scored against a
// behavioural model through a result queue, plus write-path and reset-abort steps.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic         hi_we = 1'b0;
    logic         lo_we = 1'b0;
    logic [W-1:0] wdata = '0;
    logic         busy;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .op(op),
        .opA(opA),
        .opB(opB),
        .hi_we(hi_we),
        .lo_we(lo_we),
        .wdata(wdata),
        .busy(busy),
        .done(done),
        .div_by_zero(div_by_zero),
        .hi(hi),
        .lo(lo)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } result_t;

    result_t      sb[$];
    int           checks = 0;
    int           failures = 0;
    logic [W-1:0] model_hi = '0;
    logic [W-1:0] model_lo = '0;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic result_t modelOp(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        result_t r;
        longint  p;
        int      sa;
        int      sb_i;
        r = '0;
        case (o)
            2'b00: {r.hi, r.lo} = {32'b0, a} * {32'b0, b};
            2'b01: begin
                p = longint'($signed(a)) * longint'($signed(b));
                {r.hi, r.lo} = p;
            end
            default: begin
                if (b == 0) begin
                    r.lo  = '1;
                    r.hi  = a;
                    r.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    r.lo = a / b;
                    r.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    r.lo = 32'h8000_0000;
                    r.hi = 32'h0;
                end else begin
                    sa   = a;
                    sb_i = b;
                    r.lo = sa / sb_i;
                    r.hi = sa % sb_i;
                end
            end
        endcase
        return r;
    endfunction

    // Called #1 after an edge with the unit idle; returns #1 after the accept edge.
    task automatic applyStimulus(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input bit with_write);
        op    = o;
        opA   = a;
        opB   = b;
        start = 1'b1;
        hi_we = with_write;
        wdata = 32'hDEAD_BEEF;
        sb.push_back(modelOp(o, a, b));
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        op    = 2'($urandom);
        opA   = $urandom;
        opB   = $urandom;
    endtask

    task automatic waitResult(input string tag, input bit disturb);
        int      busy_cycles;
        bit      got_done;
        result_t e;
        busy_cycles = busy ? 1 : 0;
        got_done    = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            if (busy) busy_cycles++;
            if (i == 10) begin
                checkOutput({tag, ".hold_hi"}, hi, model_hi);
                checkOutput({tag, ".hold_lo"}, lo, model_lo);
            end
            if (disturb && i == 5) begin
                start = 1'b1;
                op    = 2'b00;
                opA   = 32'h0000_0100;
                opB   = 32'h0000_0003;
                lo_we = 1'b1;
                wdata = 32'h5A5A_5A5A;
            end
            if (disturb && i == 6) begin
                start = 1'b0;
                lo_we = 1'b0;
            end
        end
        checkOutput({tag, ".done_seen"}, got_done, 1);
        e = sb.pop_front();
        checkOutput({tag, ".hi"}, hi, e.hi);
        checkOutput({tag, ".lo"}, lo, e.lo);
        checkOutput({tag, ".dbz"}, div_by_zero, e.dbz);
        checkOutput({tag, ".busy_at_done"}, busy, 0);
        checkOutput({tag, ".busy_cycles"}, busy_cycles, 33);
        model_hi = e.hi;
        model_lo = e.lo;
        @(posedge clk);
        #1;
        checkOutput({tag, ".done_width"}, done, 0);
        checkOutput({tag, ".dbz_width"}, div_by_zero, 0);
    endtask

    initial begin
        bit saw_done;
        rst_n = 1'b0;
        #12;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("reset.hi", hi, 0);
        checkOutput("reset.lo", lo, 0);
        checkOutput("reset.busy", busy, 0);
        checkOutput("reset.done", done, 0);
        checkOutput("reset.dbz", div_by_zero, 0);

        hi_we = 1'b1;
        wdata = 32'hAAAA_5555;
        @(posedge clk);
        #1;
        hi_we    = 1'b0;
        model_hi = 32'hAAAA_5555;
        checkOutput("mthi.hi", hi, model_hi);
        checkOutput("mthi.lo", lo, model_lo);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'h1357_2468;
        @(posedge clk);
        #1;
        hi_we    = 1'b0;
        lo_we    = 1'b0;
        model_hi = 32'h1357_2468;
        model_lo = 32'h1357_2468;
        checkOutput("mtboth.hi", hi, model_hi);
        checkOutput("mtboth.lo", lo, model_lo);

        applyStimulus(2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
        waitResult("mult_neg", 1'b0);
        applyStimulus(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        waitResult("multu_max", 1'b0);
        applyStimulus(2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 1'b0);
        waitResult("div_neg", 1'b0);
        applyStimulus(2'b10, 32'h0000_0007, 32'h0000_0002, 1'b0);
        waitResult("divu", 1'b0);
        applyStimulus(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        waitResult("div_ovf", 1'b0);
        applyStimulus(2'b10, 32'h1234_5678, 32'h0000_0000, 1'b0);
        waitResult("divu_zero", 1'b0);
        applyStimulus(2'b11, 32'hFEDC_BA98, 32'h0000_0000, 1'b0);
        waitResult("div_zero", 1'b0);
        applyStimulus(2'b11, 32'h0000_0064, 32'hFFFF_FFF9, 1'b0);
        waitResult("div_disturb", 1'b1);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'(k), $urandom, $urandom | 32'h1, 1'b0);
            waitResult("rand", 1'b0);
        end

        applyStimulus(2'b11, 32'h0000_1000, 32'h0000_0003, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("abort.hi", hi, 0);
        checkOutput("abort.lo", lo, 0);
        checkOutput("abort.busy", busy, 0);
        checkOutput("abort.done", done, 0);
        sb.delete();
        model_hi = '0;
        model_lo = '0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) saw_done = 1'b1;
        end
        checkOutput("abort.no_done", saw_done, 0);
        applyStimulus(2'b00, 32'd6, 32'd7, 1'b0);
        waitResult("multu_after_reset", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
